decode_scoreboard: RTL and testbench
====================================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameters: NUM_REGS, default 8, architectural register count. REG_ID_W, default 3, register-id width, with NUM_REGS = 2^REG_ID_W. CNT_W, default 2, per-register in-flight-writer counter width. BYPASS_RETIRE, default 1, same-cycle retire clears hazard. PERF_W, default 16, stall-counter width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- de_v  in  1  decode latch holds a valid instruction
- de_sr1, de_sr2, de_dr  in  REG_ID_W each  source and destination register ids
- de_sr1_needed, de_sr2_needed  in  1 each  source register is read
- de_ld_reg, de_ld_cc  in  1 each  instruction writes a register / writes the CCs
- de_br_op  in  1  instruction reads the CCs
- de_br_stall  in  1  control-flow instruction
- ld_agex  in  1  AGEX latch accepts this cycle (~mem_stall)
- sr_v_ld_reg  in  1  store-result stage retires a register write
- sr_drid  in  REG_ID_W  retiring destination register
- sr_v_ld_cc  in  1  store-result stage retires a CC write
- br_resolved  in  1  outstanding branch resolved
- dep_stall  out  1  data-hazard stall
- v_de_br_stall  out  1  stall fetch on control flow
- agex_v  out  1  valid bit into the AGEX latch
- issue  out  1  instruction leaves decode this cycle
- reg_pending  out  NUM_REGS  per-register counter nonzero
- cc_pending  out  1  CC counter nonzero
- stall_cycles  out  PERF_W  saturating count of stalled cycles
- sb_err  out  1  sticky underflow error

Function
REQ-003 Per-register counters pend[r] (CNT_W bits) and a CC counter pend_cc (CNT_W bits) SHALL count issued-but-unretired writers.
REQ-004 hz(r) SHALL be pend[r]!=0, excluding the case (BYPASS_RETIRE=1, sr_v_ld_reg, sr_drid==r, pend[r]==1). hz_cc SHALL be defined the same way using pend_cc and sr_v_ld_cc.
REQ-005 dep_stall SHALL equal de_v & ((de_sr1_needed & hz(de_sr1)) | (de_sr2_needed & hz(de_sr2)) | (de_br_op & hz_cc) | (de_ld_reg & pend[de_dr]==MAX) | (de_ld_cc & pend_cc==MAX)), where MAX = 2^CNT_W-1. This logic SHALL be combinational.
REQ-006 issue SHALL equal de_v & ld_agex & ~dep_stall & (state==IDLE).
REQ-007 agex_v SHALL equal de_v & ~dep_stall & (state==IDLE).
REQ-008 On issue & de_ld_reg, pend[de_dr] SHALL increment. On sr_v_ld_reg, pend[sr_drid] SHALL decrement. When both hit the same register in one cycle, the value SHALL be unchanged. pend_cc SHALL follow the same rules. All updates take effect on the next clk edge.
REQ-009 A decrement of a zero counter SHALL leave the counter at 0 and set sb_err. sb_err SHALL clear only on reset.
REQ-010 FSM states: IDLE and BR_WAIT. IDLE->BR_WAIT on issue & de_br_stall. BR_WAIT->IDLE on br_resolved. br_resolved in IDLE SHALL be ignored.
REQ-011 v_de_br_stall SHALL equal (de_v & de_br_stall) | (state==BR_WAIT).
REQ-012 stall_cycles SHALL increment on each cycle with de_v & ~issue, and SHALL saturate at all-ones.
REQ-013 reg_pending[r] SHALL equal pend[r]!=0. cc_pending SHALL equal pend_cc!=0. Both SHALL be registered views of the counters.

Reset
REQ-014 While reset is high, the block SHALL set all pend counters to 0, pend_cc to 0, state to IDLE, stall_cycles to 0 and sb_err to 0, and SHALL ignore all other inputs.
REQ-015 Reset asserted mid-branch or with writers in flight SHALL discard all tracking. The first post-reset cycle SHALL show dep_stall=0 for any operands.

Structure
REQ-016 The shared pipeline package SHALL hold the FSM state encoding (IDLE=0, BR_WAIT=1) and the default NUM_REGS/REG_ID_W constants.
REQ-017 A single sub-module, sb_counter (up/down counter with saturate-at-max, underflow flag and simultaneous-event hold), SHALL be instantiated NUM_REGS+1 times.

Verification
REQ-018 Issue ADD R3 (de_ld_reg, de_dr=3). Next cycle, decode needs sr1=3 -> dep_stall=1, agex_v=0. Assert sr_v_ld_reg with sr_drid=3 -> with BYPASS_RETIRE=1, dep_stall=0 that same cycle.
REQ-019 CNT_W=2: issue three writers to R5 with no retire -> reg_pending[5]=1. A fourth writer to R5 -> dep_stall=1 until a retire of R5.
REQ-020 In the same cycle, issue a write to R2 and retire R2 with pend[2]=1 -> pend[2] stays 1 and reg_pending[2]=1.
REQ-021 Issue a branch with de_br_stall=1 -> v_de_br_stall=1 and issue=0 for 5 cycles while de_v=1. Pulse br_resolved -> IDLE, issue resumes the next cycle, and stall_cycles=5.
REQ-022 Retire R7 with pend[7]=0 -> sb_err=1 and it stays set. Apply reset -> sb_err=0, all reg_pending=0, state IDLE.

Source files
------------

// File: rtl/decode_scoreboard_pkg.sv
// Shared decode-stage definitions: branch-wait FSM encoding and default scoreboard sizing.
package decode_scoreboard_pkg;

  localparam int unsigned SB_NUM_REGS = 8;
  localparam int unsigned SB_REG_ID_W = 3;
  localparam int unsigned SB_CNT_W    = 2;
  localparam int unsigned SB_PERF_W   = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } sb_state_e;

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode/retire handshake bundle between the pipeline and the decode scoreboard.
interface decode_scoreboard_if
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_NUM_REGS,
  parameter int unsigned REG_ID_W = SB_REG_ID_W,
  parameter int unsigned PERF_W   = SB_PERF_W
) ();

  logic                de_v;
  logic [REG_ID_W-1:0] de_sr1;
  logic [REG_ID_W-1:0] de_sr2;
  logic [REG_ID_W-1:0] de_dr;
  logic                de_sr1_needed;
  logic                de_sr2_needed;
  logic                de_ld_reg;
  logic                de_ld_cc;
  logic                de_br_op;
  logic                de_br_stall;
  logic                ld_agex;
  logic                sr_v_ld_reg;
  logic [REG_ID_W-1:0] sr_drid;
  logic                sr_v_ld_cc;
  logic                br_resolved;

  logic                dep_stall;
  logic                v_de_br_stall;
  logic                agex_v;
  logic                issue;
  logic [NUM_REGS-1:0] reg_pending;
  logic                cc_pending;
  logic [PERF_W-1:0]   stall_cycles;
  logic                sb_err;

  modport master (
    output de_v, de_sr1, de_sr2, de_dr, de_sr1_needed, de_sr2_needed,
           de_ld_reg, de_ld_cc, de_br_op, de_br_stall, ld_agex,
           sr_v_ld_reg, sr_drid, sr_v_ld_cc, br_resolved,
    input  dep_stall, v_de_br_stall, agex_v, issue, reg_pending,
           cc_pending, stall_cycles, sb_err
  );

  modport slave (
    input  de_v, de_sr1, de_sr2, de_dr, de_sr1_needed, de_sr2_needed,
           de_ld_reg, de_ld_cc, de_br_op, de_br_stall, ld_agex,
           sr_v_ld_reg, sr_drid, sr_v_ld_cc, br_resolved,
    output dep_stall, v_de_br_stall, agex_v, issue, reg_pending,
           cc_pending, stall_cycles, sb_err
  );

endinterface

// File: rtl/decode_scoreboard_sb_counter.sv
// In-flight writer counter: saturating increment, clamped decrement with underflow flag,
// and hold when an issue and a retire land on it in the same cycle.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             uflow_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    uflow_c = 1'b0;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) uflow_c = 1'b1;
      else           cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // nz is registered from the next value so it always mirrors cnt != 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      nz  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      nz  <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight register/CC writers, raises data-hazard
// stalls, holds fetch across unresolved branches and counts stalled decode cycles.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS      = SB_NUM_REGS,
  parameter int unsigned REG_ID_W      = SB_REG_ID_W,
  parameter int unsigned CNT_W         = SB_CNT_W,
  parameter bit          BYPASS_RETIRE = 1'b1,
  parameter int unsigned PERF_W        = SB_PERF_W
) (
  input logic                clk,
  input logic                reset,
  decode_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  sb_state_e           state, state_nxt;
  logic [CNT_W-1:0]    pend [NUM_REGS];
  logic [CNT_W-1:0]    pend_cc;
  logic [NUM_REGS-1:0] reg_inc, reg_dec, reg_uflow;
  logic                cc_uflow;
  logic                hz_sr1, hz_sr2, hz_cc, full_dr, full_cc;
  logic                idle, dep_stall_c, agex_v_c, issue_c, br_stall_c;
  logic [PERF_W-1:0]   stall_q;
  logic                err_q;

  // A writer retiring this cycle as the last one in flight no longer blocks readers
  function automatic logic hazard(input logic [CNT_W-1:0] cnt, input logic retire);
    return (cnt != '0) && !(BYPASS_RETIRE && retire && (cnt == CNT_W'(1)));
  endfunction

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign reg_inc[r] = issue_c & sb.de_ld_reg & (sb.de_dr == REG_ID_W'(r));
    assign reg_dec[r] = sb.sr_v_ld_reg & (sb.sr_drid == REG_ID_W'(r));

    sb_counter #(.CNT_W(CNT_W)) u_pend (
      .clk     (clk),
      .reset   (reset),
      .inc     (reg_inc[r]),
      .dec     (reg_dec[r]),
      .cnt     (pend[r]),
      .nz      (sb.reg_pending[r]),
      .uflow_c (reg_uflow[r])
    );
  end

  sb_counter #(.CNT_W(CNT_W)) u_pend_cc (
    .clk     (clk),
    .reset   (reset),
    .inc     (issue_c & sb.de_ld_cc),
    .dec     (sb.sr_v_ld_cc),
    .cnt     (pend_cc),
    .nz      (sb.cc_pending),
    .uflow_c (cc_uflow)
  );

  assign hz_sr1  = hazard(pend[sb.de_sr1], sb.sr_v_ld_reg && (sb.sr_drid == sb.de_sr1));
  assign hz_sr2  = hazard(pend[sb.de_sr2], sb.sr_v_ld_reg && (sb.sr_drid == sb.de_sr2));
  assign hz_cc   = hazard(pend_cc, sb.sr_v_ld_cc);
  assign full_dr = (pend[sb.de_dr] == CNT_MAX);
  assign full_cc = (pend_cc == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sb.de_v && !issue_c && (stall_q != PERF_MAX)) stall_q <= stall_q + PERF_W'(1);
      if ((|reg_uflow) || cc_uflow) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    idle        = (state == IDLE);
    dep_stall_c = sb.de_v & ((sb.de_sr1_needed & hz_sr1) | (sb.de_sr2_needed & hz_sr2) |
                             (sb.de_br_op & hz_cc) | (sb.de_ld_reg & full_dr) |
                             (sb.de_ld_cc & full_cc));
    agex_v_c    = sb.de_v & ~dep_stall_c & idle;
    issue_c     = agex_v_c & sb.ld_agex;
    br_stall_c  = (sb.de_v & sb.de_br_stall) | ~idle;
    case (state)
      IDLE:    if (issue_c && sb.de_br_stall) state_nxt = BR_WAIT;
      BR_WAIT: if (sb.br_resolved) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sb.dep_stall     = dep_stall_c;
  assign sb.agex_v        = agex_v_c;
  assign sb.issue         = issue_c;
  assign sb.v_de_br_stall = br_stall_c;
  assign sb.stall_cycles  = stall_q;
  assign sb.sb_err        = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_decode_scoreboard;

  typedef enum int {K_DEP, K_AGEX, K_ISSUE, K_BRS, K_REGP, K_CCP, K_STALL, K_ERR} kind_e;
  typedef struct {
    kind_e       k;
    int unsigned v;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  decode_scoreboard_if sb ();

  decode_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    sb.de_v = 0; sb.de_sr1 = '0; sb.de_sr2 = '0; sb.de_dr = '0;
    sb.de_sr1_needed = 0; sb.de_sr2_needed = 0; sb.de_ld_reg = 0; sb.de_ld_cc = 0;
    sb.de_br_op = 0; sb.de_br_stall = 0; sb.ld_agex = 0;
    sb.sr_v_ld_reg = 0; sb.sr_drid = '0; sb.sr_v_ld_cc = 0; sb.br_resolved = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic chk(input kind_e k, input int unsigned v, input string name);
    exp_t e;
    e.k = k; e.v = v; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wr_reg(input int dr);
    sb.de_v = 1; sb.ld_agex = 1; sb.de_ld_reg = 1; sb.de_dr = 3'(dr);
  endtask

  always @(negedge clk) begin
    int unsigned act;
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      case (e.k)
        K_DEP:   act = 32'(sb.dep_stall);
        K_AGEX:  act = 32'(sb.agex_v);
        K_ISSUE: act = 32'(sb.issue);
        K_BRS:   act = 32'(sb.v_de_br_stall);
        K_REGP:  act = 32'(sb.reg_pending);
        K_CCP:   act = 32'(sb.cc_pending);
        K_STALL: act = 32'(sb.stall_cycles);
        default: act = 32'(sb.sb_err);
      endcase
      n_cmp++;
      if (act != e.v) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.v, $time);
      end
    end
  end

  initial begin
    reset = 1'b1;
    clr();
    repeat (2) tick();
    tick(); reset = 1'b0;
    chk(K_REGP, 0, "rst_reg_pending"); chk(K_CCP, 0, "rst_cc_pending");
    chk(K_STALL, 0, "rst_stall"); chk(K_ERR, 0, "rst_err"); chk(K_BRS, 0, "rst_br_stall");

    // RAW hazard on R3 cleared by same-cycle retire
    tick(); wr_reg(3);
    chk(K_ISSUE, 1, "add_r3_issue"); chk(K_DEP, 0, "add_r3_dep");
    tick(); sb.de_v = 1; sb.ld_agex = 1; sb.de_sr1 = 3; sb.de_sr1_needed = 1;
    chk(K_DEP, 1, "raw_r3_dep"); chk(K_AGEX, 0, "raw_r3_agex"); chk(K_ISSUE, 0, "raw_r3_issue");
    chk(K_REGP, 32'h08, "raw_r3_pending");
    tick(); sb.de_v = 1; sb.ld_agex = 1; sb.de_sr1 = 3; sb.de_sr1_needed = 1;
    sb.sr_v_ld_reg = 1; sb.sr_drid = 3;
    chk(K_DEP, 0, "bypass_dep"); chk(K_ISSUE, 1, "bypass_issue"); chk(K_STALL, 1, "bypass_stall");
    tick();
    chk(K_REGP, 0, "r3_drained");

    // Three writers fill R5, a fourth stalls through the retire cycle
    repeat (3) begin
      tick(); wr_reg(5); chk(K_ISSUE, 1, "r5_fill_issue");
    end
    tick(); wr_reg(5);
    chk(K_DEP, 1, "r5_full_dep"); chk(K_ISSUE, 0, "r5_full_issue"); chk(K_REGP, 32'h20, "r5_pending");
    tick(); wr_reg(5); sb.sr_v_ld_reg = 1; sb.sr_drid = 5;
    chk(K_DEP, 1, "r5_retire_dep"); chk(K_STALL, 2, "r5_stall2");
    tick(); wr_reg(5);
    chk(K_DEP, 0, "r5_after_retire_dep"); chk(K_ISSUE, 1, "r5_after_retire_issue");
    chk(K_STALL, 3, "r5_stall3");

    // Simultaneous issue and retire on R2 holds the count
    tick(); wr_reg(2); chk(K_ISSUE, 1, "r2_first_issue");
    tick(); wr_reg(2); sb.sr_v_ld_reg = 1; sb.sr_drid = 2; chk(K_ISSUE, 1, "r2_same_cycle_issue");
    tick(); chk(K_REGP, 32'h24, "r2_held");
    tick(); sb.sr_v_ld_reg = 1; sb.sr_drid = 2;
    tick(); chk(K_REGP, 32'h20, "r2_drained");

    // CC hazard and retire bypass
    tick(); sb.de_v = 1; sb.ld_agex = 1; sb.de_ld_cc = 1; chk(K_ISSUE, 1, "cc_writer_issue");
    tick(); sb.de_v = 1; sb.ld_agex = 1; sb.de_br_op = 1;
    chk(K_DEP, 1, "cc_raw_dep"); chk(K_CCP, 1, "cc_pending");
    tick(); sb.de_v = 1; sb.ld_agex = 1; sb.de_br_op = 1; sb.sr_v_ld_cc = 1;
    chk(K_DEP, 0, "cc_bypass_dep"); chk(K_STALL, 4, "cc_stall4");

    // Reset with writers in flight discards tracking
    tick(); reset = 1'b1; sb.de_v = 1; sb.de_sr1 = 5; sb.de_sr1_needed = 1; sb.de_br_stall = 1;
    tick(); reset = 1'b0; sb.de_v = 1; sb.ld_agex = 1; sb.de_sr1 = 5; sb.de_sr1_needed = 1;
    sb.de_br_op = 1; sb.de_ld_reg = 1; sb.de_dr = 5;
    chk(K_DEP, 0, "post_rst_dep"); chk(K_REGP, 0, "post_rst_pending"); chk(K_STALL, 0, "post_rst_stall");
    chk(K_ISSUE, 1, "post_rst_issue");

    // Branch holds decode for five cycles
    tick(); sb.de_v = 1; sb.ld_agex = 1; sb.de_br_stall = 1;
    chk(K_ISSUE, 1, "br_issue"); chk(K_BRS, 1, "br_stall_out");
    repeat (5) begin
      tick(); sb.de_v = 1; sb.ld_agex = 1;
      chk(K_ISSUE, 0, "br_wait_issue"); chk(K_BRS, 1, "br_wait_stall"); chk(K_AGEX, 0, "br_wait_agex");
    end
    tick(); sb.br_resolved = 1;
    chk(K_BRS, 1, "br_resolve_cycle"); chk(K_STALL, 5, "br_stall5");
    tick(); sb.de_v = 1; sb.ld_agex = 1;
    chk(K_ISSUE, 1, "br_resume_issue"); chk(K_BRS, 0, "br_resume_stall"); chk(K_STALL, 5, "br_stall_hold");

    // br_resolved in IDLE ignored; control-flow instr blocked by mem stall stays IDLE
    tick(); sb.br_resolved = 1;
    tick(); sb.de_v = 1; sb.de_br_stall = 1;
    chk(K_ISSUE, 0, "memstall_issue"); chk(K_AGEX, 1, "memstall_agex"); chk(K_BRS, 1, "memstall_brs");
    tick(); sb.de_v = 1; sb.ld_agex = 1;
    chk(K_ISSUE, 1, "still_idle_issue"); chk(K_STALL, 6, "stall6");

    // Underflow is sticky until reset
    tick(); sb.sr_v_ld_reg = 1; sb.sr_drid = 7; chk(K_ERR, 0, "err_before");
    tick(); chk(K_ERR, 1, "err_set");
    tick(); chk(K_ERR, 1, "err_sticky");
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk(K_ERR, 0, "err_cleared"); chk(K_REGP, 0, "final_pending"); chk(K_BRS, 0, "final_brs");
    tick(); sb.de_v = 1; sb.ld_agex = 1; chk(K_ISSUE, 1, "final_issue");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
